// File: rtl/dec_hazard_ctrl.sv
// DEC/EXE hazard control: tracks in-flight register writers, stalls decode on RAW hazards,
// and flushes younger instructions after an EXE mispredict.
module dec_hazard_ctrl #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int FLUSH_CYCLES        = 1,
  parameter int WB_BYPASS           = 1,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2,
  input  logic                           dec_uses_src1,
  input  logic                           dec_uses_src2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_dst_ind,
  input  logic                           dec_reg_file_wrt_en,
  input  logic                           exe_mispredict,
  output logic                           pc_en,
  output logic                           if_dec_flush,
  output logic                           dec_exe_bubble,
  output logic                           stall,
  output logic [CNT_WIDTH-1:0]           stall_cnt
);

  localparam int          NUM_STAGES   = 3;
  localparam int          CMP_STAGES   = (WB_BYPASS != 0) ? 2 : 3;
  localparam logic [2:0]  FCNT_INIT    = 3'(FLUSH_CYCLES - 1);

  typedef struct packed {
    logic                           v;
    logic                           wrt;
    logic [REG_INDEX_BIT_WIDTH-1:0] dst;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  sb_entry_t            sb_reg [NUM_STAGES];
  state_t               state_reg;
  logic [2:0]           fcnt_reg;
  logic [CNT_WIDTH-1:0] stall_cnt_reg;

  logic [NUM_STAGES-1:0] hit1;
  logic [NUM_STAGES-1:0] hit2;
  logic                  raw;
  logic                  mispredict;
  logic                  issue;

  // WB is left out of the compare when the regfile writes before it reads.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_hit
      if (gi < CMP_STAGES) begin : g_cmp
        assign hit1[gi] = sb_reg[gi].v & sb_reg[gi].wrt & (sb_reg[gi].dst == dec_src1);
        assign hit2[gi] = sb_reg[gi].v & sb_reg[gi].wrt & (sb_reg[gi].dst == dec_src2);
      end else begin : g_nocmp
        assign hit1[gi] = 1'b0;
        assign hit2[gi] = 1'b0;
      end
    end
  endgenerate

  assign raw            = dec_valid & ((dec_uses_src1 & (|hit1)) | (dec_uses_src2 & (|hit2)));
  assign mispredict     = exe_mispredict | (state_reg == FLUSH);
  assign stall          = raw & ~mispredict;
  assign pc_en          = ~stall;
  assign if_dec_flush   = mispredict;
  assign dec_exe_bubble = stall | mispredict;
  assign issue          = dec_valid & ~dec_exe_bubble;
  assign stall_cnt      = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        sb_reg[i] <= '0;
      end
      state_reg     <= RUN;
      fcnt_reg      <= 3'd0;
      stall_cnt_reg <= '0;
    end else begin
      sb_reg[2] <= sb_reg[1];
      sb_reg[1] <= sb_reg[0];
      if (issue) begin
        sb_reg[0] <= '{v: 1'b1, wrt: dec_reg_file_wrt_en, dst: dec_dst_ind};
      end else begin
        sb_reg[0] <= '0;
      end

      if (stall && (stall_cnt_reg != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end

      case (state_reg)
        FLUSH: begin
          if (exe_mispredict) begin
            fcnt_reg <= FCNT_INIT;
          end else if (fcnt_reg == 3'd0) begin
            state_reg <= RUN;
          end else begin
            fcnt_reg <= fcnt_reg - 3'd1;
          end
        end
        default: begin
          if (exe_mispredict) begin
            state_reg <= FLUSH;
            fcnt_reg  <= FCNT_INIT;
          end else if (raw) begin
            state_reg <= STALL;
          end else begin
            state_reg <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_hazard_ctrl.sv
// Randomized bench for dec_hazard_ctrl: two instances (WB bypass on/off, different flush
// lengths) checked each cycle against a timestamp-based model of writer age and flush windows.
module tb_dec_hazard_ctrl;

  localparam int RIW = 4;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           dec_valid;
  logic [RIW-1:0] dec_src1, dec_src2, dec_dst_ind;
  logic           dec_uses_src1, dec_uses_src2, dec_reg_file_wrt_en;
  logic           exe_mispredict;

  logic           pc_en      [2];
  logic           flush      [2];
  logic           bubble     [2];
  logic           stall      [2];
  logic [CW-1:0]  cnt        [2];

  always #5 clk = ~clk;

  dec_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(RIW), .FLUSH_CYCLES(1), .WB_BYPASS(1), .CNT_WIDTH(CW)) u0 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_uses_src1(dec_uses_src1), .dec_uses_src2(dec_uses_src2), .dec_dst_ind(dec_dst_ind),
    .dec_reg_file_wrt_en(dec_reg_file_wrt_en), .exe_mispredict(exe_mispredict),
    .pc_en(pc_en[0]), .if_dec_flush(flush[0]), .dec_exe_bubble(bubble[0]), .stall(stall[0]),
    .stall_cnt(cnt[0]));

  dec_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(RIW), .FLUSH_CYCLES(3), .WB_BYPASS(0), .CNT_WIDTH(CW)) u1 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_uses_src1(dec_uses_src1), .dec_uses_src2(dec_uses_src2), .dec_dst_ind(dec_dst_ind),
    .dec_reg_file_wrt_en(dec_reg_file_wrt_en), .exe_mispredict(exe_mispredict),
    .pc_en(pc_en[1]), .if_dec_flush(flush[1]), .dec_exe_bubble(bubble[1]), .stall(stall[1]),
    .stall_cnt(cnt[1]));

  // Model: a writer issued at cycle t is hazardous during cycles t+1..t+window;
  // a mispredict at cycle t flushes cycles t..t+flush_len.
  int window    [2] = '{2, 3};
  int flush_len [2] = '{1, 3};
  int last_wr   [2][16];
  int last_mp   [2];
  int m_cnt     [2];
  int cyc = 0;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) last_wr[k][r] = -1000;
      last_mp[k] = -1000;
      m_cnt[k]   = 0;
    end
  endtask

  function automatic bit recent_writer(input int k, input int r);
    int age;
    age = cyc - last_wr[k][r];
    return (age >= 1) && (age <= window[k]);
  endfunction

  task automatic step(input bit rst, input bit v, input int s1, input int s2, input bit u1,
                      input bit u2, input int dst, input bit wrt, input bit mis);
    bit mp, raw, st;
    int age;
    #1;
    reset = rst; dec_valid = v; dec_src1 = RIW'(s1); dec_src2 = RIW'(s2);
    dec_uses_src1 = u1; dec_uses_src2 = u2; dec_dst_ind = RIW'(dst);
    dec_reg_file_wrt_en = wrt; exe_mispredict = mis;
    @(negedge clk);
    $display("cyc %0d rst=%0b v=%0b src=%0d/%0d use=%0b%0b dst=%0d w=%0b mis=%0b | stall=%0b/%0b flush=%0b/%0b cnt=%0d/%0d",
             cyc, rst, v, s1, s2, u1, u2, dst, wrt, mis, stall[0], stall[1], flush[0], flush[1], cnt[0], cnt[1]);
    for (int k = 0; k < 2; k++) begin
      age = cyc - last_mp[k];
      mp  = mis || (age >= 1 && age <= flush_len[k]);
      raw = v && ((u1 && recent_writer(k, s1)) || (u2 && recent_writer(k, s2)));
      st  = raw && !mp;
      check_eq($sformatf("u%0d.stall", k),  int'(stall[k]),  int'(st));
      check_eq($sformatf("u%0d.pc_en", k),  int'(pc_en[k]),  int'(!st));
      check_eq($sformatf("u%0d.flush", k),  int'(flush[k]),  int'(mp));
      check_eq($sformatf("u%0d.bubble", k), int'(bubble[k]), int'(st || mp));
      check_eq($sformatf("u%0d.stall_cnt", k), int'(cnt[k]), m_cnt[k]);
      if (!rst) begin
        if (st && m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
        if (mis) last_mp[k] = cyc;
        if (v && !(st || mp) && wrt) last_wr[k][dst] = cyc;
      end
    end
    if (rst) model_reset();
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    reset = 1'b1; dec_valid = 1'b0; dec_src1 = '0; dec_src2 = '0; dec_uses_src1 = 1'b0;
    dec_uses_src2 = 1'b0; dec_dst_ind = '0; dec_reg_file_wrt_en = 1'b0; exe_mispredict = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);

    // r3 writer then r3 reader held until it drains
    step(0, 1, 0, 0, 0, 0, 3, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3, 0, 1, 0, 9, 0, 0);
    // non-writer / unused source -> no stall; src2 reader stalls
    step(0, 1, 0, 0, 0, 0, 5, 0, 0);
    step(0, 1, 5, 5, 1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 5, 1, 0);
    step(0, 1, 5, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 5, 0, 1, 1, 0, 0);
    // mispredict coinciding with a raw hazard, then drain the flush
    step(0, 1, 0, 0, 0, 0, 6, 1, 0);
    step(0, 1, 6, 0, 1, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 6, 0, 1, 0, 1, 0, 0);
    // reset mid-stall abandons the hazard and clears the counter
    step(0, 1, 0, 0, 0, 0, 7, 1, 0);
    step(0, 1, 7, 0, 1, 0, 1, 0, 0);
    step(1, 1, 7, 0, 1, 0, 1, 0, 0);
    step(0, 1, 7, 0, 1, 0, 1, 0, 0);
    // long hazard chain to push the counter into saturation
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0, 0, 2, 1, 0);
      step(0, 1, 2, 0, 1, 0, 1, 0, 0);
      step(0, 1, 2, 0, 1, 0, 1, 0, 0);
      step(0, 1, 2, 0, 1, 0, 1, 0, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 1),
           ($urandom_range(0, 99) < 85),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
